// File: rtl/memory_pkg.sv
// memory_pkg: shared result-select codes and FSM state type for the memory stage
package memory_pkg;
  localparam logic [1:0] RESULT_ALU = 2'b00;
  localparam logic [1:0] RESULT_MEM = 2'b01;
  localparam logic [1:0] RESULT_PC4 = 2'b10;
  typedef enum logic {IDLE, WAIT} state_t;
endpackage

// File: rtl/memory_register.sv
// memory_register: M/W pipeline register; a bubble clears the write and fault flags and holds the rest
module memory_register (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_bubble,
  input  logic        i_reg_write,
  input  logic        i_fault,
  input  logic [4:0]  i_rd,
  input  logic [1:0]  i_result_src,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_pc_plus4,
  input  logic        i_rd_en,
  input  logic [31:0] i_read_data,
  output logic        o_reg_write,
  output logic [4:0]  o_rd,
  output logic [1:0]  o_result_src,
  output logic [31:0] o_alu_result,
  output logic [31:0] o_read_data,
  output logic [31:0] o_pc_plus4,
  output logic        o_mem_fault
);
  logic        r_reg_write;
  logic        r_fault;
  logic [4:0]  r_rd;
  logic [1:0]  r_result_src;
  logic [31:0] r_alu_result;
  logic [31:0] r_read_data;
  logic [31:0] r_pc_plus4;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_reg_write  <= 1'b0;
      r_fault      <= 1'b0;
      r_rd         <= '0;
      r_result_src <= '0;
      r_alu_result <= '0;
      r_read_data  <= '0;
      r_pc_plus4   <= '0;
    end else if (i_bubble) begin
      r_reg_write <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_reg_write  <= i_reg_write & ~i_fault;
      r_fault      <= i_fault;
      r_rd         <= i_rd;
      r_result_src <= i_result_src;
      r_alu_result <= i_alu_result;
      r_pc_plus4   <= i_pc_plus4;
      if (i_rd_en) r_read_data <= i_read_data;
    end
  end

  assign o_reg_write  = r_reg_write;
  assign o_rd         = r_rd;
  assign o_result_src = r_result_src;
  assign o_alu_result = r_alu_result;
  assign o_read_data  = r_read_data;
  assign o_pc_plus4   = r_pc_plus4;
  assign o_mem_fault  = r_fault;
endmodule

// File: rtl/memory_stage.sv
// memory_stage: issues data-memory accesses over valid/ack, stalls while outstanding,
// aborts misaligned or timed-out accesses as faults, and owns the M/W register.
module memory_stage import memory_pkg::*; #(
  parameter int          TIMEOUT    = 16,
  parameter logic [31:0] FAULT_DATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [4:0]  RdM,
  input  logic [1:0]  ResultSrcM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCPlus4M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        StallM,
  output logic        RegWriteW,
  output logic [4:0]  RdW,
  output logic [1:0]  ResultSrcW,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ResultW,
  output logic        MemFaultW
);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic            r_we;
  logic            w_idle;
  logic            w_acc;
  logic            w_mis;
  logic            w_go;
  logic            w_ack;
  logic            w_to;
  logic            w_fault;
  logic            w_rd_en;

  assign w_idle = (r_state == IDLE);
  assign w_acc  = MemWriteM | (ResultSrcM == RESULT_MEM);
  assign w_mis  = w_acc & (ALUResultM[1:0] != 2'b00);
  assign w_go   = w_idle & w_acc & ~w_mis;

  // WAIT drives from the latch so the bus stays frozen even if M inputs wiggle
  assign dmem_req   = w_go | ~w_idle;
  assign dmem_we    = w_idle ? MemWriteM  : r_we;
  assign dmem_addr  = w_idle ? ALUResultM : r_addr;
  assign dmem_wdata = w_idle ? WriteDataM : r_wdata;

  assign w_ack   = dmem_ack & dmem_req;
  // the IDLE issue cycle plus TIMEOUT-1 WAIT cycles give TIMEOUT request cycles
  assign w_to    = ~w_idle & ~dmem_ack & (r_cnt == CW'(TIMEOUT - 2));
  assign w_fault = (w_idle & w_mis) | w_to;
  assign StallM  = (w_go & ~dmem_ack) | (~w_idle & ~dmem_ack & ~w_to);
  assign w_rd_en = (w_ack & ~dmem_we) | (w_fault & ~MemWriteM);

  always_comb begin
    w_next = r_state;
    w_next = w_idle ? ((w_go & ~dmem_ack) ? WAIT : IDLE) : ((dmem_ack | w_to) ? IDLE : WAIT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_idle && w_go) begin
        r_cnt   <= '0;
        r_addr  <= ALUResultM;
        r_wdata <= WriteDataM;
        r_we    <= MemWriteM;
      end else if (!w_idle) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  memory_register u_mw (
    .clk          (clk),
    .reset        (reset),
    .i_bubble     (StallM),
    .i_reg_write  (RegWriteM),
    .i_fault      (w_fault),
    .i_rd         (RdM),
    .i_result_src (ResultSrcM),
    .i_alu_result (ALUResultM),
    .i_pc_plus4   (PCPlus4M),
    .i_rd_en      (w_rd_en),
    .i_read_data  (w_ack ? dmem_rdata : FAULT_DATA),
    .o_reg_write  (RegWriteW),
    .o_rd         (RdW),
    .o_result_src (ResultSrcW),
    .o_alu_result (ALUResultW),
    .o_read_data  (ReadDataW),
    .o_pc_plus4   (PCPlus4W),
    .o_mem_fault  (MemFaultW)
  );

  always_comb begin
    ResultW = '0;
    ResultW = (ResultSrcW == RESULT_ALU) ? ALUResultW :
              (ResultSrcW == RESULT_MEM) ? ReadDataW :
              (ResultSrcW == RESULT_PC4) ? PCPlus4W : 32'h0;
  end
endmodule
